tag_compare_wb: RTL

//  Successor tag comparator in the DRAM-cache controller. Sits between the memory-ctrl R channel (tag+data burst),
//  the tag/wbuffer FIFOs and the ROB/AR/AW/W/fill queues. Classifies each request as RHIT/RMISS/WHIT/WMISS.

---
 rtl/dram_cache_pkg.sv | 37 +++
 rtl/tag_cmp_stats.sv | 40 ++++
 rtl/tag_compare_wb.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dram_cache_pkg.sv
// rtl/dram_cache_pkg.sv - shared types and field layout for the DRAM-cache tag comparator
//
// Purpose: state encoding for tag_compare_wb, the default widths of the cache
//          configuration, and the bit positions of the metadata fields in
//          the R-channel beat and of the WR flag in a tag-FIFO entry.
// Ports:   none (package).
package dram_cache_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RHIT  = 3'd1,
      RMISS = 3'd2,
      WHIT  = 3'd3,
      WMISS = 3'd4
   } tc_state_e;

   localparam int DC_ADDR_WIDTH   = 16;
   localparam int DC_DATA_WIDTH   = 32;
   localparam int DC_ID_WIDTH     = 4;
   localparam int DC_TID_WIDTH    = 4;
   localparam int DC_INDEX_WIDTH  = 6;
   localparam int DC_OFFSET_WIDTH = 2;
   localparam int DC_TAG_WIDTH    = DC_ADDR_WIDTH - DC_INDEX_WIDTH - DC_OFFSET_WIDTH;
   localparam int DC_TAG_SIZE     = 16;
   localparam int DC_STAT_WIDTH   = 32;

   // Metadata layout {VALID,DIRTY,TAG,BLANK}, positions counted from the
   // metadata LSB; in the R beat the metadata sits above DATA_WIDTH data bits.
   localparam int VALID_BIT = DC_TAG_SIZE - 1;
   localparam int DIRTY_BIT = DC_TAG_SIZE - 2;
   localparam int TAG_MSB   = DC_TAG_SIZE - 3;
   localparam int TAG_LSB   = TAG_MSB - DC_TAG_WIDTH + 1;

   // Tag-FIFO entry is {WR,TID,ADDR}.
   localparam int WR_BIT    = DC_TID_WIDTH + DC_ADDR_WIDTH;

endpackage

// File: rtl/tag_cmp_stats.sv
// rtl/tag_cmp_stats.sv - saturating request-classification counters
//
// Purpose: five saturating counters, one per request class plus victim
//          write-backs. clr zeroes all counters and wins over increments.
// Ports:   clk, rst_n (sync, active low), clr,
//          inc[4:0] = {wb, wmiss, whit, rmiss, rhit} single-cycle pulses,
//          stat_* counter values.
module tag_cmp_stats #(
   parameter int STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic [4:0]            inc,
   output logic [STAT_WIDTH-1:0] stat_rhit,
   output logic [STAT_WIDTH-1:0] stat_rmiss,
   output logic [STAT_WIDTH-1:0] stat_whit,
   output logic [STAT_WIDTH-1:0] stat_wmiss,
   output logic [STAT_WIDTH-1:0] stat_wb
);

   logic [STAT_WIDTH-1:0] cnt [5];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (!rst_n || clr) begin
            cnt[i] <= '0;
         end else if (inc[i] && (cnt[i] != '1)) begin
            cnt[i] <= cnt[i] + STAT_WIDTH'(1);
         end
      end
   end

   assign stat_rhit  = cnt[0];
   assign stat_rmiss = cnt[1];
   assign stat_whit  = cnt[2];
   assign stat_wmiss = cnt[3];
   assign stat_wb    = cnt[4];

endmodule

// File: rtl/tag_compare_wb.sv
// rtl/tag_compare_wb.sv - DRAM-cache tag comparator with dirty-victim write-back
//
// Purpose: pairs each R beat (metadata + line) with the tag-FIFO request,
//          classifies it as RHIT/RMISS/WHIT/WMISS and issues to ROB, AR,
//          AW+W (dirty victim only) and the fill port. One request in flight.
// Ports:   clk, rst_n; R channel rid_i/rdata_i/rvalid_i/rready_o;
//          tag FIFO (FWFT) tag_fifo_*; write-data buffer (FWFT) wbuffer_*;
//          rob_*, ar_fifo_*, aw_fifo_*, w_fifo_* write ports with afull;
//          fill_valid_o/fill_ready_i/fill_data_o = {DIRTY=1,ADDR,DATA}.
// Config:  TAG_CMP_STATS_EN adds stats_clr_i and stat_{rhit,rmiss,whit,wmiss,wb}_o.
module tag_compare_wb
   import dram_cache_pkg::*;
#(
   parameter int ADDR_WIDTH   = DC_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DC_DATA_WIDTH,
   parameter int ID_WIDTH     = DC_ID_WIDTH,
   parameter int TAG_SIZE     = DC_TAG_SIZE,
   parameter int INDEX_WIDTH  = DC_INDEX_WIDTH,
   parameter int OFFSET_WIDTH = DC_OFFSET_WIDTH,
   parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
   parameter int TID_WIDTH    = DC_TID_WIDTH,
   parameter int STAT_WIDTH   = DC_STAT_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [ID_WIDTH-1:0]              rid_i,
   input  logic [TAG_SIZE+DATA_WIDTH-1:0]   rdata_i,
   input  logic                             rvalid_i,
   output logic                             rready_o,
   input  logic                             tag_fifo_aempty_i,
   output logic                             tag_fifo_rden_o,
   input  logic [TID_WIDTH+ADDR_WIDTH:0]    tag_fifo_data_i,
   input  logic                             wbuffer_aempty_i,
   output logic                             wbuffer_rden_o,
   input  logic [DATA_WIDTH-1:0]            wbuffer_data_i,
   input  logic                             rob_afull_i,
   output logic                             rob_wren_o,
   output logic [TID_WIDTH+DATA_WIDTH-1:0]  rob_data_o,
   input  logic                             ar_fifo_afull_i,
   output logic                             ar_fifo_wren_o,
   output logic [TID_WIDTH+ADDR_WIDTH-1:0]  ar_fifo_data_o,
   input  logic                             aw_fifo_afull_i,
   output logic                             aw_fifo_wren_o,
   output logic [ADDR_WIDTH-1:0]            aw_fifo_data_o,
   input  logic                             w_fifo_afull_i,
   output logic                             w_fifo_wren_o,
   output logic [DATA_WIDTH-1:0]            w_fifo_data_o,
   input  logic                             fill_ready_i,
   output logic                             fill_valid_o,
   output logic [ADDR_WIDTH+DATA_WIDTH:0]   fill_data_o
`ifdef TAG_CMP_STATS_EN
   ,
   input  logic                             stats_clr_i,
   output logic [STAT_WIDTH-1:0]            stat_rhit_o,
   output logic [STAT_WIDTH-1:0]            stat_rmiss_o,
   output logic [STAT_WIDTH-1:0]            stat_whit_o,
   output logic [STAT_WIDTH-1:0]            stat_wmiss_o,
   output logic [STAT_WIDTH-1:0]            stat_wb_o
`endif
);

   // Field positions inside the full R beat for this instance's widths.
   localparam int V_POS   = DATA_WIDTH + TAG_SIZE - 1;
   localparam int D_POS   = DATA_WIDTH + TAG_SIZE - 2;
   localparam int TMSB    = DATA_WIDTH + TAG_SIZE - 3;
   localparam int TLSB    = TMSB - TAG_WIDTH + 1;
   localparam int WR_POS  = TID_WIDTH + ADDR_WIDTH;

   tc_state_e state;
   logic      evict_q, ar_done, wb_done, fill_done;

   logic                    req_wr, hit, evict, accept;
   logic [TID_WIDTH-1:0]    req_tid;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [TAG_WIDTH-1:0]    meta_tag;
   logic [INDEX_WIDTH-1:0]  req_index;
   logic                    wb_fire, fill_fire, ar_ok, wb_ok, fill_ok;
   logic [4:0]              stat_inc;
   logic                    unused_bits;

   assign req_wr    = tag_fifo_data_i[WR_POS];
   assign req_tid   = tag_fifo_data_i[ADDR_WIDTH +: TID_WIDTH];
   assign req_addr  = tag_fifo_data_i[ADDR_WIDTH-1:0];
   assign req_index = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign meta_tag  = rdata_i[TMSB:TLSB];

   assign hit   = rdata_i[V_POS] && (req_addr[ADDR_WIDTH-1 -: TAG_WIDTH] == meta_tag);
   assign evict = !hit && rdata_i[V_POS] && rdata_i[D_POS];

   // A write needs its data in the wbuffer before anything is popped.
   assign accept = rst_n && (state == IDLE) && rvalid_i && !tag_fifo_aempty_i &&
                   (!req_wr || !wbuffer_aempty_i);

   assign rready_o        = accept;
   assign tag_fifo_rden_o = accept;
   assign wbuffer_rden_o  = accept && req_wr;

   // Issue strobes come from registered state and done flags; gating with
   // rst_n keeps a request interrupted by reset from issuing anything.
   assign rob_wren_o     = rst_n && (state == RHIT) && !rob_afull_i;
   assign ar_fifo_wren_o = rst_n && (state == RMISS) && !ar_done && !ar_fifo_afull_i;
   assign wb_fire        = rst_n && ((state == RMISS) || (state == WMISS)) && evict_q &&
                           !wb_done && !aw_fifo_afull_i && !w_fifo_afull_i;
   assign aw_fifo_wren_o = wb_fire;
   assign w_fifo_wren_o  = wb_fire;
   assign fill_valid_o   = rst_n && ((state == WHIT) || (state == WMISS)) && !fill_done;
   assign fill_fire      = fill_valid_o && fill_ready_i;

   assign ar_ok   = ar_done || ar_fifo_wren_o;
   assign wb_ok   = !evict_q || wb_done || wb_fire;
   assign fill_ok = fill_done || fill_fire;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         evict_q        <= 1'b0;
         ar_done        <= 1'b0;
         wb_done        <= 1'b0;
         fill_done      <= 1'b0;
         rob_data_o     <= '0;
         ar_fifo_data_o <= '0;
         aw_fifo_data_o <= '0;
         w_fifo_data_o  <= '0;
         fill_data_o    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rob_data_o     <= {req_tid, rdata_i[DATA_WIDTH-1:0]};
                  ar_fifo_data_o <= {req_tid, req_addr};
                  aw_fifo_data_o <= {meta_tag, req_index, {OFFSET_WIDTH{1'b0}}};
                  w_fifo_data_o  <= rdata_i[DATA_WIDTH-1:0];
                  fill_data_o    <= {1'b1, req_addr, wbuffer_data_i};
                  evict_q        <= evict;
                  ar_done        <= 1'b0;
                  wb_done        <= 1'b0;
                  fill_done      <= 1'b0;
                  state          <= req_wr ? (hit ? WHIT : WMISS) : (hit ? RHIT : RMISS);
               end
            end
            RHIT: begin
               if (rob_wren_o) state <= IDLE;
            end
            RMISS: begin
               ar_done <= ar_ok;
               wb_done <= wb_done || wb_fire;
               if (ar_ok && wb_ok) state <= IDLE;
            end
            WHIT: begin
               if (fill_fire) state <= IDLE;
            end
            WMISS: begin
               fill_done <= fill_ok;
               wb_done   <= wb_done || wb_fire;
               if (fill_ok && wb_ok) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stat_inc = {wb_fire,
                      accept && req_wr && !hit,
                      accept && req_wr && hit,
                      accept && !req_wr && !hit,
                      accept && !req_wr && hit};

`ifdef TAG_CMP_STATS_EN
   tag_cmp_stats #(.STAT_WIDTH(STAT_WIDTH)) u_stats (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (stats_clr_i),
      .inc        (stat_inc),
      .stat_rhit  (stat_rhit_o),
      .stat_rmiss (stat_rmiss_o),
      .stat_whit  (stat_whit_o),
      .stat_wmiss (stat_wmiss_o),
      .stat_wb    (stat_wb_o)
   );
   assign unused_bits = ^{rid_i, rdata_i[TLSB-1:DATA_WIDTH]};
`else
   assign unused_bits = ^{rid_i, rdata_i[TLSB-1:DATA_WIDTH], stat_inc};
`endif

endmodule
